proc_ctrl_fsm: RTL and testbench

// Control sequencer for the 9-bit processor datapath. Latches an instruction from DIN on Run,

---
 rtl/proc_pkg.sv | 33 +++
 rtl/reg_sel_dec.sv | 16 +
 rtl/proc_ctrl_fsm.sv | 122 ++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor control path: instruction
// format (III XXX YYY), opcode values and sequencer step encodings.
package proc_pkg;

  localparam int IR_W     = 9;
  localparam int NUM_REGS = 8;
  localparam int OP_W     = 3;
  localparam int RSEL_W   = 3;

  // Field positions inside the instruction word.
  localparam int OP_LSB = 6;
  localparam int X_LSB  = 3;
  localparam int Y_LSB  = 0;

  localparam logic [OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [RSEL_W-1:0] x;
    logic [RSEL_W-1:0] y;
  } instr_t;

endpackage

// File: rtl/reg_sel_dec.sv
// 3-to-8 one-hot register select decoder with enable; all-zero when disabled.
module reg_sel_dec
  import proc_pkg::*;
(
  input  logic              en,
  input  logic [RSEL_W-1:0] sel,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Control sequencer for the 9-bit processor: fetches an instruction on Run in T0,
// then steps T1..T3 driving bus-mux selects, register load enables and AddSub.
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter int DATA_W = 9,  // only the default is supported (III XXX YYY)
  parameter int NREG   = 8   // only the default is supported
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [NREG-1:0]   R_out,
  output logic              G_out,
  output logic              DIN_out,
  output logic [NREG-1:0]   R_in,
  output logic              A_in,
  output logic              G_in,
  output logic              AddSub,
  output logic              Done,
  output logic              Busy
);

  state_e            state, state_nxt;
  instr_t            ir;
  logic              rout_en, rin_en;
  logic [RSEL_W-1:0] rout_sel, rin_sel;

  // The reset clears IR as well, so a freshly reset part never decodes stale bits.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge.
      state <= state_nxt;
      if (state == T0 && Run) ir <= DIN;
    end
  end

  // Outputs depend on (state, ir) only; Run influences just the next step.
  always_comb begin
    state_nxt = state;
    rout_en   = 1'b0;
    rout_sel  = ir.y;
    rin_en    = 1'b0;
    rin_sel   = ir.x;
    G_out     = 1'b0;
    DIN_out   = 1'b0;
    A_in      = 1'b0;
    G_in      = 1'b0;
    AddSub    = 1'b0;
    Done      = 1'b0;
    Busy      = 1'b0;

    case (state)
      T0: begin
        if (Run) state_nxt = T1;
      end

      T1: begin
        Busy = 1'b1;
        case (ir.op)
          OP_MV: begin
            rout_en   = 1'b1;
            rin_en    = 1'b1;
            Done      = 1'b1;
            state_nxt = T0;
          end
          OP_MVI: begin
            DIN_out   = 1'b1;
            rin_en    = 1'b1;
            Done      = 1'b1;
            state_nxt = T0;
          end
          OP_ADD, OP_SUB: begin
            rout_en   = 1'b1;
            rout_sel  = ir.x;
            A_in      = 1'b1;
            state_nxt = T2;
          end
          default: begin
            // Reserved opcodes retire as a one-step NOP.
            Done      = 1'b1;
            state_nxt = T0;
          end
        endcase
      end

      T2: begin
        Busy      = 1'b1;
        rout_en   = 1'b1;
        G_in      = 1'b1;
        AddSub    = (ir.op == OP_SUB);
        state_nxt = T3;
      end

      T3: begin
        Busy      = 1'b1;
        G_out     = 1'b1;
        rin_en    = 1'b1;
        Done      = 1'b1;
        state_nxt = T0;
      end

      default: state_nxt = T0;
    endcase
  end

  reg_sel_dec u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (R_out)
  );

  reg_sel_dec u_rin_dec (
    .en     (rin_en),
    .sel    (rin_sel),
    .onehot (R_in)
  );

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Self-checking bench for proc_ctrl_fsm: directed instruction cases, reset
// abandonment, back-to-back streaming and randomized traffic against a step model.
module tb_proc_ctrl_fsm;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Run;
  logic [8:0] DIN;
  logic [7:0] R_out, R_in;
  logic       G_out, DIN_out, A_in, G_in, AddSub, Done, Busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [22:0] exp_q[$];

  always #5 Clock = ~Clock;

  proc_ctrl_fsm dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Run     (Run),
    .DIN     (DIN),
    .R_out   (R_out),
    .G_out   (G_out),
    .DIN_out (DIN_out),
    .R_in    (R_in),
    .A_in    (A_in),
    .G_in    (G_in),
    .AddSub  (AddSub),
    .Done    (Done),
    .Busy    (Busy)
  );

  // Packed view: {R_out, G_out, DIN_out, R_in, A_in, G_in, AddSub, Done, Busy}.
  function automatic logic [22:0] obs();
    return {R_out, G_out, DIN_out, R_in, A_in, G_in, AddSub, Done, Busy};
  endfunction

  function automatic logic [22:0] mk(input logic [7:0] ro, input logic go, input logic di,
                                     input logic [7:0] ri, input logic ai, input logic gi,
                                     input logic as, input logic dn, input logic bz);
    return {ro, go, di, ri, ai, gi, as, dn, bz};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reference model: the per-cycle outputs an instruction produces after its fetch.
  task automatic model_fetch(input logic [8:0] instr);
    int op, x, y;
    logic [7:0] bx, by;
    op = int'(instr[8:6]);
    x  = int'(instr[5:3]);
    y  = int'(instr[2:0]);
    bx = 8'(1 << x);
    by = 8'(1 << y);
    case (op)
      0: exp_q.push_back(mk(by, 0, 0, bx, 0, 0, 0, 1, 1));
      1: exp_q.push_back(mk(8'h00, 0, 1, bx, 0, 0, 0, 1, 1));
      2, 3: begin
        exp_q.push_back(mk(bx, 0, 0, 8'h00, 1, 0, 0, 0, 1));
        exp_q.push_back(mk(by, 0, 0, 8'h00, 0, 1, (op == 3), 0, 1));
        exp_q.push_back(mk(8'h00, 1, 0, bx, 0, 0, 0, 1, 1));
      end
      default: exp_q.push_back(mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 1));
    endcase
  endtask

  // Bus exclusivity, one-hot enables, AddSub confined to T2, quiet outputs when idle.
  always @(negedge Clock) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0({|R_out, G_out, DIN_out}) || !$onehot0(R_out) || !$onehot0(R_in) ||
          (AddSub && !G_in) || (!Busy && obs() != 23'h0)) begin
        errors++;
        $display("FAIL bus_exclusive t=%0t outputs=%h", $time, obs());
      end
    end
  end

  task automatic test_reset();
    checks++;
    if (obs() !== 23'h0) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs(), 23'h0);
    end
    repeat (2) tick();
    Resetn = 1'b1;

    // Abandon an add in T2.
    Run = 1'b1;
    DIN = 9'b010_001_011;
    tick();
    Run = 1'b0;
    tick();
    checks++;
    if (obs() !== mk(8'h08, 0, 0, 8'h00, 0, 1, 0, 0, 1)) begin
      errors++;
      $display("FAIL pre_reset_t2 got=%h want=%h", obs(), mk(8'h08, 0, 0, 8'h00, 0, 1, 0, 0, 1));
    end
    #2 Resetn = 1'b0;
    #1;
    checks++;
    if (obs() !== 23'h0) begin
      errors++;
      $display("FAIL reset_async got=%h want=%h", obs(), 23'h0);
    end
    tick();
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== 23'h0) begin
        errors++;
        $display("FAIL after_release cycle=%0d got=%h want=%h", i, obs(), 23'h0);
      end
    end
  endtask

  task automatic test_directed_ops();
    logic [8:0]  d_tab[7];
    logic [22:0] e_tab[7][3];
    int          n_tab[7];
    d_tab = '{9'b001_011_000, 9'b000_010_110, 9'b010_001_011, 9'b011_001_011,
              9'b111_000_000, 9'b000_101_101, 9'b100_111_111};
    n_tab = '{1, 1, 3, 3, 1, 1, 1};
    e_tab[0] = '{mk(8'h00, 0, 1, 8'h08, 0, 0, 0, 1, 1), 23'h0, 23'h0};
    e_tab[1] = '{mk(8'h40, 0, 0, 8'h04, 0, 0, 0, 1, 1), 23'h0, 23'h0};
    e_tab[2] = '{mk(8'h02, 0, 0, 8'h00, 1, 0, 0, 0, 1), mk(8'h08, 0, 0, 8'h00, 0, 1, 0, 0, 1),
                 mk(8'h00, 1, 0, 8'h02, 0, 0, 0, 1, 1)};
    e_tab[3] = '{mk(8'h02, 0, 0, 8'h00, 1, 0, 0, 0, 1), mk(8'h08, 0, 0, 8'h00, 0, 1, 1, 0, 1),
                 mk(8'h00, 1, 0, 8'h02, 0, 0, 0, 1, 1)};
    e_tab[4] = '{mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 1), 23'h0, 23'h0};
    e_tab[5] = '{mk(8'h20, 0, 0, 8'h20, 0, 0, 0, 1, 1), 23'h0, 23'h0};
    e_tab[6] = '{mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 1), 23'h0, 23'h0};
    for (int t = 0; t < 7; t++) begin
      Run = 1'b1;
      DIN = d_tab[t];
      checks++;
      if (obs() !== 23'h0) begin
        errors++;
        $display("FAIL op%0d_t0 got=%h want=%h", t, obs(), 23'h0);
      end
      tick();
      Run = 1'b0;
      DIN = 9'h005;
      for (int k = 0; k < n_tab[t]; k++) begin
        checks++;
        if (obs() !== e_tab[t][k]) begin
          errors++;
          $display("FAIL op%0d_step%0d got=%h want=%h", t, k + 1, obs(), e_tab[t][k]);
        end
        tick();
      end
      checks++;
      if (obs() !== 23'h0) begin
        errors++;
        $display("FAIL op%0d_return_t0 got=%h want=%h", t, obs(), 23'h0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] prog[3];
    int         fetch_c[3];
    int         start;
    bit         fetched, exp_done;
    prog  = '{9'b001_010_000, 9'b010_010_011, 9'b000_100_010};
    start = 1;
    for (int i = 0; i < 3; i++) begin
      fetch_c[i] = start;
      start += (prog[i][8:7] == 2'b01) ? 4 : 2;
    end
    for (int c = 1; c <= 9; c++) begin
      fetched = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (c == fetch_c[i]) begin
          Run     = 1'b1;
          DIN     = prog[i];
          fetched = 1'b1;
        end
      end
      if (!fetched) begin
        Run = (c == 9) ? 1'b0 : 1'($urandom);
        DIN = 9'($urandom);
      end
      exp_done = (c == 2) || (c == 6) || (c == 8);
      checks++;
      if (Done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done cycle=%0d got=%b want=%b", c, Done, exp_done);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [22:0] exp;
    bit          fetch;
    int          n;
    n = 0;
    while (n < 600 || exp_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        exp   = 23'h0;
        Run   = (n < 600) ? ($urandom_range(0, 3) != 0) : 1'b0;
        DIN   = 9'($urandom);
        fetch = Run;
      end else begin
        exp   = exp_q.pop_front();
        Run   = 1'($urandom);
        DIN   = 9'($urandom);
        fetch = 1'b0;
      end
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL random cycle=%0d din=%h got=%h want=%h", n, DIN, obs(), exp);
      end
      if (fetch) model_fetch(DIN);
      tick();
      n++;
    end
  endtask

  initial begin
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = 9'h000;
    mon_en = 1'b1;
    #1;
    test_reset();
    test_directed_ops();
    test_back_to_back();
    test_random();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
